// File: rtl/imul_iter_ctrl.sv
// imul_iter_ctrl: FSM sequencing the iterative shift-and-add multiplier datapath
module imul_iter_ctrl #(
  parameter int p_nbits = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic istream_val,
  output logic istream_rdy,
  output logic ostream_val,
  input  logic ostream_rdy,
  input  logic b_lsb,
  output logic a_en,
  output logic b_en,
  output logic result_en,
  output logic a_mux_sel,
  output logic b_mux_sel,
  output logic result_mux_sel,
  output logic add_mux_sel
);
  localparam int cw = ($clog2(p_nbits) > 1) ? $clog2(p_nbits) : 1;
  localparam logic [cw-1:0] last = cw'(p_nbits - 1);
  localparam logic [1:0] s_idle = 2'd0;
  localparam logic [1:0] s_calc = 2'd1;
  localparam logic [1:0] s_done = 2'd2;
  logic [1:0] state;
  logic [cw-1:0] cnt;
  logic idle, calc, done;
  always_ff @(posedge clk)
    if (reset) begin
      state <= s_idle;
      cnt   <= '0;
    end else
      case (state)
        s_idle: if (istream_val) begin
          state <= s_calc;
          cnt   <= '0;
        end
        s_calc: begin
          cnt <= (cnt == last) ? '0 : cnt + 1'b1;
          if (cnt == last) state <= s_done;
        end
        s_done: if (ostream_rdy) state <= s_idle;
        default: begin
          state <= s_idle;
          cnt   <= '0;
        end
      endcase
  // decoded states are gated by reset so every output is 0 while it is held
  assign idle = !reset && state == s_idle;
  assign calc = !reset && state == s_calc;
  assign done = !reset && state == s_done;
  assign istream_rdy    = idle;
  assign ostream_val    = done;
  assign a_en           = calc || (idle && istream_val);
  assign b_en           = a_en;
  assign result_en      = a_en;
  assign a_mux_sel      = idle;
  assign b_mux_sel      = idle;
  assign result_mux_sel = idle;
  assign add_mux_sel    = calc && b_lsb;
endmodule

// File: tb/tb_imul_iter_ctrl.sv
// tb_imul_iter_ctrl: drives the controller against a behavioural datapath and scoreboards products
module tb_imul_iter_ctrl;
  logic clk = 0, reset = 1, reset4 = 1;
  logic istream_val = 0, ostream_rdy = 0;
  logic istream_rdy, ostream_val, b_lsb, a_en, b_en, result_en;
  logic a_mux_sel, b_mux_sel, result_mux_sel, add_mux_sel;
  logic [31:0] a_in = 0, b_in = 0, ra = 0, rb = 0, rr = 0;
  logic istream_val4 = 0, ostream_rdy4 = 0;
  logic istream_rdy4, ostream_val4, b_lsb4, a_en4, b_en4, result_en4;
  logic a_mux_sel4, b_mux_sel4, result_mux_sel4, add_mux_sel4;
  logic [3:0] a4_in = 0, b4_in = 0, ra4 = 0, rb4 = 0, rr4 = 0;
  int cyc = 0, n_chk = 0, n_bad = 0, t0 = 0, last_hs4 = -1;
  logic prev_oval = 0;
  logic [31:0] exp_p[$];
  int exp_c[$];
  logic [3:0] exp_p4[$];

  imul_iter_ctrl #(.p_nbits(32)) dut (
    .clk(clk), .reset(reset), .istream_val(istream_val), .istream_rdy(istream_rdy),
    .ostream_val(ostream_val), .ostream_rdy(ostream_rdy), .b_lsb(b_lsb),
    .a_en(a_en), .b_en(b_en), .result_en(result_en), .a_mux_sel(a_mux_sel),
    .b_mux_sel(b_mux_sel), .result_mux_sel(result_mux_sel), .add_mux_sel(add_mux_sel)
  );

  imul_iter_ctrl #(.p_nbits(4)) dut4 (
    .clk(clk), .reset(reset4), .istream_val(istream_val4), .istream_rdy(istream_rdy4),
    .ostream_val(ostream_val4), .ostream_rdy(ostream_rdy4), .b_lsb(b_lsb4),
    .a_en(a_en4), .b_en(b_en4), .result_en(result_en4), .a_mux_sel(a_mux_sel4),
    .b_mux_sel(b_mux_sel4), .result_mux_sel(result_mux_sel4), .add_mux_sel(add_mux_sel4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural datapaths steered only by the controller outputs
  always @(posedge clk) begin
    if (a_en) ra <= a_mux_sel ? a_in : ra << 1;
    if (b_en) rb <= b_mux_sel ? b_in : rb >> 1;
    if (result_en) rr <= result_mux_sel ? 32'd0 : (add_mux_sel ? rr + ra : rr);
    if (a_en4) ra4 <= a_mux_sel4 ? a4_in : ra4 << 1;
    if (b_en4) rb4 <= b_mux_sel4 ? b4_in : rb4 >> 1;
    if (result_en4) rr4 <= result_mux_sel4 ? 4'd0 : (add_mux_sel4 ? rr4 + ra4 : rr4);
  end
  assign b_lsb  = rb[0];
  assign b_lsb4 = rb4[0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_oval(input int n);
    int k = 0;
    while (!ostream_val && k < n) begin
      @(negedge clk);
      k++;
    end
    if (!ostream_val) check("oval_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (reset)
      check("rst_outs", {istream_rdy, ostream_val, a_en, b_en, result_en,
                         a_mux_sel, b_mux_sel, result_mux_sel, add_mux_sel}, 0);
    else begin
      if (istream_val && istream_rdy) begin
        exp_p.push_back(a_in * b_in);
        exp_c.push_back(cyc + 33);
      end
      if (ostream_val && !prev_oval) begin
        if (exp_c.size() == 0) check("unexp_oval", 1, 0);
        else check("oval_cyc", cyc, exp_c[0]);
      end
      if (ostream_val && ostream_rdy && exp_p.size() > 0) begin
        check("prod", rr, exp_p[0]);
        exp_p.pop_front();
        exp_c.pop_front();
      end
    end
    prev_oval = ostream_val;
  end

  always @(negedge clk) begin
    if (!reset4) begin
      if (istream_val4 && istream_rdy4) begin
        if (last_hs4 >= 0) check("hs_gap4", cyc - last_hs4, 6);
        last_hs4 = cyc;
        exp_p4.push_back(a4_in * b4_in);
      end
      if (ostream_val4 && ostream_rdy4) begin
        if (exp_p4.size() == 0) check("unexp_o4", 1, 0);
        else begin
          check("prod4", rr4, exp_p4[0]);
          exp_p4.pop_front();
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick;
    reset = 0;
    reset4 = 0;
    @(negedge clk);
    check("post_rst_rdy", istream_rdy, 1);
    check("post_rst_en", {a_en, b_en, result_en, ostream_val}, 0);
    // single transaction 3*5 with output backpressure
    tick;
    istream_val = 1; a_in = 32'd3; b_in = 32'd5; ostream_rdy = 0;
    @(negedge clk);
    check("hs1", istream_rdy, 1);
    t0 = cyc;
    tick;
    istream_val = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("calc_en", {a_en, b_en, result_en}, 3'b111);
      check("calc_add", add_mux_sel, (i == 0 || i == 2));
      check("calc_rdy", {istream_rdy, ostream_val}, 0);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) check("lat1", cyc - t0, 33);
      check("bp_oval", ostream_val, 1);
      check("bp_en", {a_en, b_en, result_en, istream_rdy}, 0);
    end
    tick;
    ostream_rdy = 1;
    @(negedge clk);
    check("bp_last", ostream_val, 1);
    tick;
    @(negedge clk);
    check("bp_idle", {istream_rdy, ostream_val}, 2'b10);
    // ignored inputs during CALC
    tick;
    istream_val = 1; a_in = 32'h1234; b_in = 32'h89ab;
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < 32; i++) begin
      tick;
      istream_val = 1'($urandom);
      a_in = $urandom;
      b_in = $urandom;
      @(negedge clk);
      check("ign_st", {istream_rdy, ostream_val, a_en, b_en, result_en}, 5'b00111);
    end
    tick;
    istream_val = 0;
    @(negedge clk);
    check("ign_oval", ostream_val, 1);
    check("ign_lat", cyc - t0, 33);
    tick;
    @(negedge clk);
    check("ign_idle", istream_rdy, 1);
    // reset at CALC iteration 10
    tick;
    istream_val = 1; a_in = 32'd7; b_in = 32'd9;
    @(negedge clk);
    tick;
    istream_val = 0;
    repeat (10) tick;
    reset = 1;
    exp_p.delete();
    exp_c.delete();
    @(negedge clk);
    tick;
    reset = 0;
    @(negedge clk);
    check("mid_idle", {istream_rdy, ostream_val, a_en, b_en, result_en}, 5'b10000);
    repeat (3) begin
      @(negedge clk);
      check("mid_no_oval", ostream_val, 0);
    end
    tick;
    istream_val = 1; a_in = 32'hffff_ffff; b_in = 32'd3;
    @(negedge clk);
    check("hs3", istream_rdy, 1);
    t0 = cyc;
    tick;
    istream_val = 0;
    wait_oval(40);
    check("lat3", cyc - t0, 33);
    tick;
    @(negedge clk);
    check("idle3", istream_rdy, 1);
    // back-to-back on the 4-bit instance
    tick;
    istream_val4 = 1; ostream_rdy4 = 1; a4_in = 4'd3; b4_in = 4'd5;
    for (int t = 0; t < 4; t++)
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        check("rdy4", istream_rdy4, (j == 0));
        tick;
        a4_in = 4'($urandom);
        b4_in = 4'($urandom);
      end
    istream_val4 = 0;
    repeat (8) @(negedge clk);
    check("q4_empty", exp_p4.size(), 0);
    check("q_empty", exp_p.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
